ps2_port_rx: RTL and testbench

- PicoBlaze port-mapped PS/2 keyboard receiver with a parametrised receive FIFO, status/control register and level interrupt.
- Sits on the kcpsm3 port bus next to the display and serial blocks; its in_port is OR-ed into the shared CPU read-data bus.
- Receives device-to-host PS/2 frames only; no host-to-device transmit.

---
 rtl/ps2_port_rx.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_ps2_port_rx.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_port_rx.sv
// ps2_port_rx: PS/2 device-to-host receiver on the kcpsm3 port bus.
// Conditions the PS/2 pins (synchroniser + clock glitch filter), decodes
// 11-bit frames, queues good bytes in a small FIFO and exposes the FIFO,
// a sticky status/control register and a level interrupt to the CPU.
module ps2_port_rx #(
    parameter logic [7:0] BASE_PORT       = 8'h84,
    parameter int         FIFO_DEPTH_LOG2 = 4,
    parameter int         FILTER_LEN      = 8,
    parameter int         TIMEOUT_CYCLES  = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    input  logic       write_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       irq,
    input  logic       ps2_clk,
    input  logic       ps2_data
);

    localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
    localparam int PTR_W  = FIFO_DEPTH_LOG2;
    localparam int CNT_W  = FIFO_DEPTH_LOG2 + 1;
    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    // BASE_PORT is even, so the status register sits at BASE_PORT with bit0 set.
    localparam logic [7:0]        STATUS_PORT = BASE_PORT | 8'h01;
    localparam logic [FILT_W-1:0] FILT_LAST   = FILT_W'(FILTER_LEN - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning state
    // ------------------------------------------------------------------
    logic              clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic              dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic              filt_clk_q, filt_clk_d;
    logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic              fall_s;
    logic              data_bit_s;

    // ------------------------------------------------------------------
    // Frame decoder state
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_bit_q, par_bit_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              push_s;
    logic              frm_set_s;
    logic              par_set_s;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              nonempty_s;
    logic              full_s;
    logic              pop_s;
    logic              push_ok_s;
    logic              ovf_set_s;

    // ------------------------------------------------------------------
    // Register file / bus state
    // ------------------------------------------------------------------
    logic              irq_en_q, irq_en_d;
    logic              ovf_q, ovf_d;
    logic              par_err_q, par_err_d;
    logic              frm_err_q, frm_err_d;
    logic              wr_status_s;
    logic [7:0]        status_s;
    logic [7:0]        in_port_q, in_port_d;
    logic              irq_q, irq_d;
    logic              unused_out_bits_s;

    // Control-register bits 7:6 and 1:0 carry no function.
    assign unused_out_bits_s = ^{out_port[7:6], out_port[1:0]};

    // Synchronise both pins and run the clock glitch filter / fall detector.
    always_comb begin
        clk_s1_d   = ps2_clk;
        clk_s2_d   = clk_s1_q;
        dat_s1_d   = ps2_data;
        dat_s2_d   = dat_s1_q;
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_clk_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                // FILTER_LEN-th consecutive differing sample: accept it.
                filt_clk_d = clk_s2_q;
                filt_cnt_d = '0;
            end else begin
                filt_cnt_d = filt_cnt_q + FILT_W'(1);
            end
        end else begin
            filt_cnt_d = '0;
        end
        // The fall is seen in the same cycle the filter commits to 0, and the
        // data pin is sampled in that very cycle.
        fall_s     = filt_clk_q & ~filt_clk_d;
        data_bit_s = dat_s2_q;
    end

    // Conditioning registers; the pins idle high, so reset to 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
            filt_clk_q <= filt_clk_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    // Frame decoder next-state: start/data/parity/stop plus mid-frame timeout.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        tmo_cnt_d = tmo_cnt_q;
        push_s    = 1'b0;
        frm_set_s = 1'b0;
        par_set_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_cnt_d = '0;
                if (fall_s) begin
                    if (!data_bit_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        // A fall with data high cannot be a start bit.
                        frm_set_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (fall_s) begin
                    shift_d = {data_bit_s, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (fall_s) begin
                    par_bit_d = data_bit_s;
                    state_d   = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (fall_s) begin
                    state_d = ST_IDLE;
                    if (!data_bit_s) begin
                        frm_set_s = 1'b1;
                    end else if ((^{shift_q, par_bit_q}) == 1'b0) begin
                        par_set_s = 1'b1;
                    end else begin
                        push_s = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Watchdog for a stalled device: reload on every fall inside a frame.
        if (state_q != ST_IDLE) begin
            if (fall_s) begin
                tmo_cnt_d = '0;
            end else if (tmo_cnt_q == TMO_LAST) begin
                state_d   = ST_IDLE;
                bit_cnt_d = 3'd0;
                shift_d   = 8'h00;
                tmo_cnt_d = '0;
                frm_set_s = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end else begin
            tmo_cnt_d = '0;
        end
    end

    // Frame decoder registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            par_bit_q <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // FIFO bookkeeping; a simultaneous pop frees the slot a full push needs.
    always_comb begin
        nonempty_s = (count_q != '0);
        full_s     = (count_q == CNT_FULL);
        pop_s      = read_strobe && (port_id == BASE_PORT) && nonempty_s;
        push_ok_s  = push_s && (!full_s || pop_s);
        ovf_set_s  = push_s && full_s && !pop_s;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Control/status register, read mux and interrupt; set beats clear.
    always_comb begin
        wr_status_s = write_strobe && (port_id == STATUS_PORT);
        if (wr_status_s) begin
            irq_en_d = out_port[5];
        end else begin
            irq_en_d = irq_en_q;
        end
        ovf_d     = (ovf_q     & ~(wr_status_s & out_port[2])) | ovf_set_s;
        par_err_d = (par_err_q & ~(wr_status_s & out_port[3])) | par_set_s;
        frm_err_d = (frm_err_q & ~(wr_status_s & out_port[4])) | frm_set_s;
        status_s  = {2'b00, irq_en_q, frm_err_q, par_err_q, ovf_q, full_s, nonempty_s};
        if (port_id == BASE_PORT) begin
            in_port_d = nonempty_s ? mem_q[rd_ptr_q] : 8'h00;
        end else if (port_id == STATUS_PORT) begin
            in_port_d = status_s;
        end else begin
            in_port_d = 8'h00;
        end
        irq_d = irq_en_q & nonempty_s;
    end

    // Register-file flops and registered bus outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            in_port_q <= 8'h00;
            irq_q     <= 1'b0;
        end else begin
            irq_en_q  <= irq_en_d;
            ovf_q     <= ovf_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            in_port_q <= in_port_d;
            irq_q     <= irq_d;
        end
    end

    assign in_port = in_port_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_ps2_port_rx.sv
// Self-checking bench for ps2_port_rx: drives PS/2 frames and kcpsm3 port
// cycles, keeps a queue of expected FIFO bytes plus a model of the sticky
// flags, and compares every port read against that model.
module tb_ps2_port_rx;

    localparam logic [7:0] BASE   = 8'h84;
    localparam logic [7:0] STAT   = 8'h85;
    localparam int         DEPTH  = 16;
    localparam int         FLEN   = 8;
    localparam int         TMO    = 1000;
    localparam int         HALF   = 30;

    logic       clk;
    logic       reset;
    logic [7:0] port_id;
    logic       read_strobe;
    logic       write_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       irq;
    logic       ps2_clk;
    logic       ps2_data;

    int checks;
    int errors;

    logic [7:0] exp_q [$];
    logic       m_irq_en;
    logic       m_ovf;
    logic       m_par;
    logic       m_frm;

    ps2_port_rx #(
        .BASE_PORT      (BASE),
        .FIFO_DEPTH_LOG2(4),
        .FILTER_LEN     (FLEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .port_id     (port_id),
        .read_strobe (read_strobe),
        .write_strobe(write_strobe),
        .out_port    (out_port),
        .in_port     (in_port),
        .irq         (irq),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_status();
        return {2'b00, m_irq_en, m_frm, m_par, m_ovf,
                exp_q.size() == DEPTH, exp_q.size() != 0};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_irq_en = 1'b0;
        m_ovf    = 1'b0;
        m_par    = 1'b0;
        m_frm    = 1'b0;
    endtask

    task automatic read_status(input string name);
        logic [7:0] exp;
        exp = exp_status();
        @(negedge clk);
        port_id     = STAT;
        read_strobe = 1'b1;
        @(negedge clk);
        read_strobe = 1'b0;
        port_id     = 8'h00;
        checks++;
        if (in_port !== exp) begin
            errors++;
            $display("FAIL %s status got %02h want %02h", name, in_port, exp);
        end
    endtask

    task automatic read_data(input string name);
        logic [7:0] exp;
        exp = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        @(negedge clk);
        port_id     = BASE;
        read_strobe = 1'b1;
        @(negedge clk);
        read_strobe = 1'b0;
        port_id     = 8'h00;
        checks++;
        if (in_port !== exp) begin
            errors++;
            $display("FAIL %s data got %02h want %02h", name, in_port, exp);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic write_ctrl(input logic [7:0] v);
        @(negedge clk);
        port_id      = STAT;
        out_port     = v;
        write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
        port_id      = 8'h00;
        m_irq_en = v[5];
        if (v[2]) m_ovf = 1'b0;
        if (v[3]) m_par = 1'b0;
        if (v[4]) m_frm = 1'b0;
    endtask

    task automatic check_irq(input string name);
        logic exp;
        @(negedge clk);
        exp = m_irq_en && (exp_q.size() != 0);
        checks++;
        if (irq !== exp) begin
            errors++;
            $display("FAIL %s irq got %0b want %0b", name, irq, exp);
        end
    endtask

    // One PS/2 bit cell: data set while clock high, then a low phase.
    // Optionally a sub-filter glitch in the high phase, or a data-port read
    // aimed at the exact cycle the fall is recognised (2 sync + FLEN filter).
    task automatic ps2_bit(input logic b, input bit glitch, input bit pop_at_fall,
                           output logic [7:0] rd);
        rd       = 8'h00;
        ps2_data = b;
        if (glitch) begin
            repeat (12) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (FLEN - 1) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF - 12 - (FLEN - 1)) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2_clk = 1'b0;
        if (pop_at_fall) begin
            repeat (FLEN + 1) @(negedge clk);
            port_id     = BASE;
            read_strobe = 1'b1;
            @(negedge clk);
            read_strobe = 1'b0;
            port_id     = 8'h00;
            rd          = in_port;
            repeat (HALF - FLEN - 2) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop,
                              input int glitch_bit, input bit pop_at_stop);
        logic [7:0] rd;
        logic [7:0] exp;
        logic       par;
        par = (~^d) ^ bad_par;
        exp = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        ps2_bit(1'b0, glitch_bit == 0, 1'b0, rd);
        for (int i = 0; i < 8; i++) begin
            ps2_bit(d[i], glitch_bit == i + 1, 1'b0, rd);
        end
        ps2_bit(par, glitch_bit == 9, 1'b0, rd);
        ps2_bit(stop, 1'b0, pop_at_stop, rd);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        if (pop_at_stop) begin
            checks++;
            if (rd !== exp) begin
                errors++;
                $display("FAIL pop_at_stop data got %02h want %02h", rd, exp);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (!stop) begin
            m_frm = 1'b1;
        end else if (bad_par) begin
            m_par = 1'b1;
        end else if (exp_q.size() < DEPTH) begin
            exp_q.push_back(d);
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks++;
        if (in_port !== 8'h00 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got in_port=%02h irq=%0b want 00/0", in_port, irq);
        end
        reset = 1'b1;
        model_reset();
        read_status("reset_status");
        read_data("reset_data");
        check_irq("reset_irq");
    endtask

    task automatic test_single_frame();
        send_frame(8'h1C, 1'b0, 1'b1, -1, 1'b0);
        write_ctrl(8'h20);
        check_irq("single_irq_on");
        read_status("single_status_21");
        read_data("single_data_1c");
        read_status("single_status_20");
        check_irq("single_irq_off");
    endtask

    task automatic test_errors();
        write_ctrl(8'h00);
        send_frame(8'h1C, 1'b1, 1'b1, -1, 1'b0);
        read_status("parity_err");
        write_ctrl(8'h08);
        read_status("parity_clear");
        send_frame(8'h1C, 1'b0, 1'b0, -1, 1'b0);
        read_status("stop_err");
        write_ctrl(8'h10);
        read_status("stop_clear");
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 17; i++) begin
            send_frame(8'(i), 1'b0, 1'b1, -1, 1'b0);
        end
        read_status("ovf_full");
        for (int i = 0; i < 17; i++) begin
            read_data("ovf_drain");
        end
        read_status("ovf_empty");
        write_ctrl(8'h04);
        read_status("ovf_clear");
    endtask

    task automatic test_timeout();
        logic [7:0] rd;
        ps2_bit(1'b0, 1'b0, 1'b0, rd);
        ps2_bit(1'b1, 1'b0, 1'b0, rd);
        ps2_bit(1'b0, 1'b0, 1'b0, rd);
        ps2_bit(1'b1, 1'b0, 1'b0, rd);
        ps2_data = 1'b1;
        repeat (TMO + 100) @(negedge clk);
        m_frm = 1'b1;
        read_status("timeout_frm");
        send_frame(8'h5A, 1'b0, 1'b1, -1, 1'b0);
        read_status("timeout_next");
        read_data("timeout_5a");
        write_ctrl(8'h10);
        read_status("timeout_clear");
    endtask

    task automatic test_glitch_full_pop();
        ps2_data = 1'b1;
        repeat (12) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FLEN - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        read_status("glitch_idle");
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'h30 + 8'(i), 1'b0, 1'b1, (i == 3) ? 4 : -1, 1'b0);
        end
        read_status("glitch_full");
        send_frame(8'h77, 1'b0, 1'b1, -1, 1'b1);
        read_status("full_pop_push");
        for (int i = 0; i < DEPTH; i++) begin
            read_data("full_pop_drain");
        end
        read_status("full_pop_empty");
    endtask

    task automatic test_reset_midframe();
        logic [7:0] rd;
        send_frame(8'h11, 1'b0, 1'b1, -1, 1'b0);
        ps2_bit(1'b0, 1'b0, 1'b0, rd);
        ps2_bit(1'b1, 1'b0, 1'b0, rd);
        ps2_bit(1'b1, 1'b0, 1'b0, rd);
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_reset();
        read_status("midreset_status");
        send_frame(8'hA5, 1'b0, 1'b1, -1, 1'b0);
        read_status("midreset_next");
        read_data("midreset_a5");
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        port_id      = 8'h00;
        read_strobe  = 1'b0;
        write_strobe = 1'b0;
        out_port     = 8'h00;
        ps2_clk      = 1'b1;
        ps2_data     = 1'b1;
        model_reset();
        test_reset();
        test_single_frame();
        test_errors();
        test_overflow();
        test_timeout();
        test_glitch_full_pop();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
